adder_seq_ctrl: RTL and testbench

- Multi-precision add/subtract sequencer built around one shared bitwise_adder_24bit instance.
- Accepts WORDS×24-bit operands through a valid/ready handshake.
- Feeds the adder one 24-bit word per cycle, least-significant word first, chaining the carry in a register between words.
- Presents the full-width result and final carry through a second valid/ready handshake.

---
 rtl/adder_pkg.sv | 18 +
 rtl/bitwise_adder_24bit.sv | 27 ++
 rtl/adder_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_adder_seq_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared word width, depth limit and controller state encoding for the
// multi-precision add/subtract sequencer.
`default_nettype none

package adder_pkg;

   localparam int WORD_W    = 24;
   localparam int MAX_WORDS = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : adder_pkg

`default_nettype wire

// File: rtl/bitwise_adder_24bit.sv
// 24-bit ripple-carry adder built from per-bit full adders.
`default_nettype none

module bitwise_adder_24bit
   import adder_pkg::*;
(
   input  logic [WORD_W-1:0] a_i,
   input  logic [WORD_W-1:0] b_i,
   input  logic              carry_i,
   output logic [WORD_W-1:0] sum_o,
   output logic              carry_o
);

   logic [WORD_W:0] w_c;

   assign w_c[0] = carry_i;

   for (genvar gi = 0; gi < WORD_W; gi++) begin : g_bit
      assign sum_o[gi]  = a_i[gi] ^ b_i[gi] ^ w_c[gi];
      assign w_c[gi+1]  = (a_i[gi] & b_i[gi]) | (w_c[gi] & (a_i[gi] ^ b_i[gi]));
   end

   assign carry_o = w_c[WORD_W];

endmodule : bitwise_adder_24bit

`default_nettype wire

// File: rtl/adder_seq_ctrl.sv
// Multi-precision add/subtract sequencer: one shared 24-bit adder, fed one
// word per cycle LSW first, carry chained through a register.
`default_nettype none

module adder_seq_ctrl
   import adder_pkg::*;
#(
   parameter int WORDS = 3
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    op_sub,
   input  logic [WORDS*WORD_W-1:0] a,
   input  logic [WORDS*WORD_W-1:0] b,
   input  logic                    carry_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WORDS*WORD_W-1:0] sum,
   output logic                    carry_out,
   output logic                    busy
);

   localparam int                 IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(WORDS - 1);

   if (WORDS < 1 || WORDS > MAX_WORDS) begin : g_bad_words
      $fatal(1, "adder_seq_ctrl: WORDS=%0d outside 1..%0d", WORDS, MAX_WORDS);
   end

   state_t                    state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [WORDS*WORD_W-1:0]   a_q, a_d;
   logic [WORDS*WORD_W-1:0]   b_q, b_d;
   logic [WORDS*WORD_W-1:0]   sum_q, sum_d;
   logic                      carry_q, carry_d;
   logic                      cout_q, cout_d;

   logic [WORD_W-1:0]         w_a_word;
   logic [WORD_W-1:0]         w_b_word;
   logic [WORD_W-1:0]         w_sum_word;
   logic                      w_carry;

   assign w_a_word = a_q[idx_q*WORD_W +: WORD_W];
   assign w_b_word = b_q[idx_q*WORD_W +: WORD_W];

   bitwise_adder_24bit u_adder (
      .a_i     (w_a_word),
      .b_i     (w_b_word),
      .carry_i (carry_q),
      .sum_o   (w_sum_word),
      .carry_o (w_carry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      case (state_q)
         ST_IDLE: begin
            // Subtract is a + ~b + 1, so invert b once here and seed the carry.
            if (in_valid) begin
               a_d     = a;
               b_d     = op_sub ? ~b : b;
               carry_d = op_sub ? 1'b1 : carry_in;
               idx_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            sum_d[idx_q*WORD_W +: WORD_W] = w_sum_word;
            carry_d = w_carry;
            if (idx_q == LAST_IDX) begin
               cout_d  = w_carry;
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign sum       = sum_q;
   assign carry_out = cout_q;

endmodule : adder_seq_ctrl

`default_nettype wire

// File: tb/tb_adder_seq_ctrl.sv
// Directed self-checking bench for adder_seq_ctrl with WORDS=3.
`default_nettype none

module tb_adder_seq_ctrl;

   localparam int WORDS = 3;
   localparam int W     = WORDS * 24;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic         op_sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         carry_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         carry_out;
   logic         busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   adder_seq_ctrl #(.WORDS(WORDS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_sub    (op_sub),
      .a         (a),
      .b         (b),
      .carry_in  (carry_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry_out (carry_out),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd72();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[W-1:0];
   endfunction

   // Drive a request on a negedge and return just after the accepting edge,
   // scrambling the operand inputs so only the sampled values may matter.
   task automatic start_op(input logic sub, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic cin);
      @(negedge clk);
      in_valid = 1'b1; op_sub = sub; a = av; b = bv; carry_in = cin;
      @(posedge clk); #1;
      in_valid = 1'b0; op_sub = ~sub; a = rnd72(); b = rnd72(); carry_in = ~cin;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic run_op(input string tag, input logic sub, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic cin,
                         input logic [W-1:0] es, input logic ec);
      int n;
      start_op(sub, av, bv, cin);
      wait_done(n);
      chk({tag, "_lat"}, W'(n), W'(WORDS));
      chk({tag, "_sum"}, sum, es);
      chk({tag, "_cout"}, W'(carry_out), W'(ec));
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_idle"}, W'({in_ready, out_valid, busy}), W'(3'b100));
   endtask

   initial begin
      int n;
      int prev_acc;
      logic [W-1:0] ta [4];
      logic [W-1:0] tb [4];
      logic         ts [4];
      logic         tc [4];
      logic [W:0]   ref_full;
      logic [W-1:0] held_sum;
      logic         held_cout;

      rst_n = 1'b0; in_valid = 1'b0; op_sub = 1'b0; a = '0; b = '0;
      carry_in = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", W'({in_ready, out_valid, busy, carry_out}), W'(4'b1000));
      chk("rst_sum", sum, '0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("t1_add", 1'b0, 72'h000000_000000_FFFFFF, 72'h1, 1'b0,
             72'h000000_000001_000000, 1'b0);
      run_op("t2_wrap", 1'b0, {W{1'b1}}, 72'h1, 1'b0, '0, 1'b1);
      run_op("t2_cin", 1'b0, 72'h7FFFFF, 72'h1, 1'b1, 72'h800001, 1'b0);
      run_op("t3_sub", 1'b1, 72'h000001_000000_000000, 72'h1, 1'b0,
             72'h000000_FFFFFF_FFFFFF, 1'b1);
      run_op("t3_borrow", 1'b1, '0, 72'h1, 1'b1, {W{1'b1}}, 1'b0);

      // Backpressure: result held while a new request waits on in_valid.
      start_op(1'b0, 72'h5, 72'h7, 1'b0);
      wait_done(n);
      chk("t4_lat", W'(n), W'(WORDS));
      held_sum  = sum;
      held_cout = carry_out;
      chk("t4_first", W'({held_cout, held_sum}), {1'b0, 72'hC});
      @(negedge clk);
      in_valid = 1'b1; op_sub = 1'b1; a = 72'h300; b = 72'h100; carry_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("t4_hold_sum", sum, held_sum);
         chk("t4_hold_flags", W'({carry_out, in_ready, out_valid}), W'({held_cout, 2'b01}));
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("t4_idle", W'(in_ready), W'(1));
      @(posedge clk); #1;
      in_valid = 1'b0; a = '0; b = '0; op_sub = 1'b0;
      chk("t4_accept", W'(busy), W'(1));
      wait_done(n);
      chk("t4_lat2", W'(n), W'(WORDS));
      chk("t4_sum2", sum, 72'h200);
      chk("t4_cout2", W'(carry_out), W'(1));
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Reset after the second RUN cycle.
      start_op(1'b0, 72'h000000_000000_FFFFFF, 72'h1, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_sum", sum, '0);
      chk("t5_rst_flags", W'({carry_out, out_valid, busy}), W'(3'b000));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("t5_ready", W'(in_ready), W'(1));
      run_op("t5_rerun", 1'b0, 72'h000000_000000_FFFFFF, 72'h1, 1'b0,
             72'h000000_000001_000000, 1'b0);

      // Back-to-back with in_valid and out_ready held high.
      for (int i = 0; i < 4; i++) begin
         ta[i] = rnd72(); tb[i] = rnd72();
         ts[i] = 1'(i % 2); tc[i] = 1'($urandom_range(0, 1));
      end
      ta[3] = tb[3];
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1;
      op_sub = ts[0]; a = ta[0]; b = tb[0]; carry_in = tc[0];
      prev_acc = 0;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
         end
         chk("t6_ready", W'(in_ready), W'(1));
         @(posedge clk); #1;
         if (i > 0) chk("t6_spacing", W'(cyc - prev_acc), W'(WORDS + 2));
         prev_acc = cyc;
         if (i < 3) begin
            op_sub = ts[i+1]; a = ta[i+1]; b = tb[i+1]; carry_in = tc[i+1];
         end else begin
            in_valid = 1'b0;
         end
         wait_done(n);
         chk("t6_lat", W'(n), W'(WORDS));
         if (ts[i]) begin
            ref_full = {(ta[i] >= tb[i]), ta[i] - tb[i]};
         end else begin
            ref_full = {1'b0, ta[i]} + {1'b0, tb[i]} + {{W{1'b0}}, tc[i]};
         end
         chk("t6_sum", sum, ref_full[W-1:0]);
         chk("t6_cout", W'(carry_out), W'(ref_full[W]));
         @(posedge clk); #1;
      end
      out_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_adder_seq_ctrl

`default_nettype wire
